// File: rtl/ace_loader_pkg.sv
// rtl/ace_loader_pkg.sv - state encoding and constants shared by the ACE snapshot loader
package ace_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LIT,
        CNT,
        DATA,
        FILL,
        END
    } loader_state_t;

    localparam logic [7:0] RLE_MARKER = 8'hED;

endpackage

// File: rtl/rle_run_counter.sv
// rtl/rle_run_counter.sv - loadable down-counter with zero/last flags for run length and end timer
module rle_run_counter #(
    parameter int W = 8
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o,
    output logic         last_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);
    assign last_o  = (count_q == W'(1));

endmodule

// File: rtl/ace_rle_loader.sv
// rtl/ace_rle_loader.sv - ED-marker RLE snapshot loader into Jupiter Ace RAM
// Optional running XOR of written bytes on `checksum` when LOADER_CHECKSUM_EN is defined.
module ace_rle_loader
    import ace_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h2000,
    parameter int unsigned TIMEOUT   = 3_000_000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_wr,
    output logic        mem_sel,
    output logic        core_reset
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]  checksum
`endif
);

    localparam int TW = $clog2(TIMEOUT + 1);

    loader_state_t state_q, state_d;
    logic          dl_q;
    logic          wait_q, wait_d;
    logic          wr_q, wr_d;
    logic          sel_q, sel_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    din_q, din_d;

    logic          cnt_load, cnt_dec, cnt_zero, cnt_last;
    logic [7:0]    cnt_val;
    logic          tmr_load, tmr_dec, tmr_zero, tmr_last;
    logic [TW-1:0] tmr_val;

    logic start, stop, accept;

    assign start  = ioctl_download && !dl_q && (ioctl_index != 8'd0);
    assign stop   = !ioctl_download && dl_q;
    // Strobes during wait are protocol violations and are simply dropped.
    assign accept = ioctl_wr && !wait_q;

    rle_run_counter #(.W(8)) u_cnt (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .load_i     (cnt_load),
        .load_val_i (ioctl_dout),
        .dec_i      (cnt_dec),
        .count_o    (cnt_val),
        .zero_o     (cnt_zero),
        .last_o     (cnt_last)
    );

    rle_run_counter #(.W(TW)) u_timer (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (TW'(TIMEOUT)),
        .dec_i      (tmr_dec),
        .count_o    (tmr_val),
        .zero_o     (tmr_zero),
        .last_o     (tmr_last)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dl_q    <= 1'b0;
            wait_q  <= 1'b0;
            wr_q    <= 1'b0;
            sel_q   <= 1'b0;
            addr_q  <= BASE_ADDR;
            din_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            dl_q    <= ioctl_download;
            wait_q  <= wait_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = LIT;
        end else if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                LIT:  if (accept && ioctl_dout == RLE_MARKER) state_d = CNT;
                CNT:  if (accept) state_d = (ioctl_dout == 8'd0) ? END : DATA;
                DATA: if (accept) state_d = FILL;
                FILL: if (cnt_last || cnt_zero) state_d = LIT;
                default: ;
            endcase
        end
    end

    // The address advances the cycle after each write, so literals and fills share one rule.
    always_comb begin
        wait_d   = wait_q;
        wr_d     = 1'b0;
        sel_d    = sel_q;
        din_d    = din_q;
        addr_d   = wr_q ? addr_q + 16'd1 : addr_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        if (start) begin
            addr_d = BASE_ADDR;
            sel_d  = 1'b1;
            wait_d = 1'b0;
        end else if (stop) begin
            sel_d  = 1'b0;
            wait_d = 1'b0;
        end else begin
            case (state_q)
                LIT: if (accept && ioctl_dout != RLE_MARKER) begin
                    wr_d  = 1'b1;
                    din_d = ioctl_dout;
                end
                CNT: if (accept) begin
                    if (ioctl_dout == 8'd0) begin
                        wait_d   = (TIMEOUT != 0);
                        tmr_load = 1'b1;
                    end else begin
                        cnt_load = 1'b1;
                    end
                end
                DATA: if (accept) begin
                    din_d  = ioctl_dout;
                    wait_d = 1'b1;
                end
                FILL: begin
                    wr_d    = !cnt_zero;
                    cnt_dec = 1'b1;
                    if (cnt_last || cnt_zero) wait_d = 1'b0;
                end
                END: if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                    if (tmr_last) wait_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ioctl_wait = wait_q;
    assign mem_wr     = wr_q;
    assign mem_addr   = addr_q;
    assign mem_din    = din_q;
    assign mem_sel    = sel_q;
    assign core_reset = sel_q;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            csum_q <= 8'd0;
        end else if (start) begin
            csum_q <= 8'd0;
        end else if (wr_q) begin
            csum_q <= csum_q ^ din_q;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_ace_rle_loader.sv
// tb/tb_ace_rle_loader.sv - randomized check of ace_rle_loader against a stream-level model
module tb_ace_rle_loader;

    localparam int T = 16;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_dout = 8'd0;

    logic        wait_a, wr_a, sel_a, crst_a;
    logic [15:0] addr_a;
    logic [7:0]  din_a;
    logic        wait_b, wr_b, sel_b, crst_b;
    logic [15:0] addr_b;
    logic [7:0]  din_b;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_a, csum_b;
`endif

    ace_rle_loader #(.BASE_ADDR(16'h2000), .TIMEOUT(T)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(wait_a), .mem_addr(addr_a), .mem_din(din_a), .mem_wr(wr_a),
        .mem_sel(sel_a), .core_reset(crst_a)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(csum_a)
`endif
    );

    ace_rle_loader #(.BASE_ADDR(16'hFFFE), .TIMEOUT(T)) dut_w (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(wait_b), .mem_addr(addr_b), .mem_din(din_b), .mem_wr(wr_b),
        .mem_sel(sel_b), .core_reset(crst_b)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(csum_b)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    wr_t         act_a[$];
    wr_t         act_b[$];
    wr_t         exp_q[$];
    logic [7:0]  stim[$];
    logic [7:0]  strobe_b[$];
    int          strobe_c[$];
    int          wait_cnt = 0;
    int          exp_wait = 0;
    logic [7:0]  exp_cs = 8'd0;
    bit          mon_en = 1'b0;

    always @(negedge clk_sys) begin
        if (mon_en) begin
            if (wr_a) act_a.push_back('{addr_a, din_a, cyc});
            if (wr_b) act_b.push_back('{addr_b, din_b, cyc});
            if (wait_a) wait_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit force_it);
        int guard = 0;
        if (!force_it) begin
            while (wait_a && guard < 1000) begin
                @(negedge clk_sys);
                guard++;
            end
            check("wait_low_before_strobe", wait_a, 0);
        end
        strobe_b.push_back(b);
        strobe_c.push_back(cyc);
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    // Expected writes from the byte stream: literals, ED n b runs, ED 00 end marker,
    // with any strobe landing inside a wait window discarded.
    task automatic build_model();
        int mode = 0;
        int n = 0;
        int off = 0;
        int hi_end = -1;
        exp_q.delete();
        exp_wait = 0;
        foreach (strobe_b[i]) begin
            int c;
            logic [7:0] b;
            c = strobe_c[i];
            b = strobe_b[i];
            if (c <= hi_end) continue;
            case (mode)
                0: if (b != 8'hED) begin
                    exp_q.push_back('{16'(off), b, c + 1});
                    off++;
                end else mode = 1;
                1: if (b == 8'd0) begin
                    mode = 3;
                    exp_wait += T;
                    hi_end = c + T;
                end else begin
                    n = b;
                    mode = 2;
                end
                2: begin
                    for (int j = 0; j < n; j++) begin
                        exp_q.push_back('{16'(off), b, c + 2 + j});
                        off++;
                    end
                    exp_wait += n;
                    hi_end = c + n;
                    mode = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_log(input string nm, input logic [15:0] base, input bit use_b);
        int sz;
        sz = use_b ? act_b.size() : act_a.size();
        check({nm, "_write_count"}, sz, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < sz; i++) begin
            wr_t e;
            logic [15:0] ea;
            e  = use_b ? act_b[i] : act_a[i];
            ea = base + exp_q[i].addr;
            check({nm, "_addr"}, e.addr, ea);
            check({nm, "_data"}, e.data, exp_q[i].data);
            check({nm, "_cycle"}, e.cyc, exp_q[i].cyc);
        end
    endtask

    task automatic run_load(input logic [7:0] idx, input int force_at);
        int guard = 0;
        strobe_b.delete();
        strobe_c.delete();
        act_a.delete();
        act_b.delete();
        wait_cnt = 0;
        @(negedge clk_sys);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        mon_en         = 1'b1;
        @(negedge clk_sys);
        foreach (stim[i]) begin
            if (i != force_at) repeat ($urandom_range(0, 2)) @(negedge clk_sys);
            send_byte(stim[i], i == force_at);
        end
        while (wait_a && guard < 1000) begin
            @(negedge clk_sys);
            guard++;
        end
        repeat (3) @(negedge clk_sys);
        check("mem_sel_during_load", sel_a, 32'(idx != 0));
        check("core_reset_during_load", crst_a, 32'(idx != 0));
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("mem_sel_after_end", sel_a, 0);
        check("core_reset_after_end", crst_a, 0);
        check("wait_after_end", wait_a, 0);
        @(negedge clk_sys);
        mon_en = 1'b0;
        if (idx != 0) begin
            build_model();
            exp_cs = 8'd0;
            foreach (exp_q[i]) exp_cs ^= exp_q[i].data;
        end else begin
            exp_q.delete();
            exp_wait = 0;
        end
        compare_log("base2000", 16'h2000, 1'b0);
        compare_log("baseFFFE", 16'hFFFE, 1'b1);
        check("wait_high_cycles", wait_cnt, exp_wait);
`ifdef LOADER_CHECKSUM_EN
        check("checksum_a", csum_a, exp_cs);
        check("checksum_b", csum_b, exp_cs);
`endif
    endtask

    task automatic check_reset_values();
        check("rst_wait", wait_a, 0);
        check("rst_mem_wr", wr_a, 0);
        check("rst_mem_sel", sel_a, 0);
        check("rst_core_reset", crst_a, 0);
        check("rst_addr_a", addr_a, 16'h2000);
        check("rst_addr_b", addr_b, 16'hFFFE);
        check("rst_din", din_a, 0);
`ifdef LOADER_CHECKSUM_EN
        check("rst_checksum", csum_a, 0);
`endif
    endtask

    initial begin
        int seen;
        int guard;
        repeat (3) @(negedge clk_sys);
        check_reset_values();
        reset_n = 1'b1;

        stim = '{8'h11, 8'h22, 8'h33};
        run_load(8'd1, -1);
        stim = '{8'hED, 8'h05, 8'hAA, 8'h66};
        run_load(8'd1, -1);
        stim = '{8'hED, 8'h00, 8'h44};
        run_load(8'd3, -1);
        stim = '{8'hED, 8'h04, 8'h5A};
        run_load(8'd1, -1);
        stim = '{8'h0F, 8'hF0, 8'h3C};
        run_load(8'd2, -1);
        stim = '{8'h12, 8'hED, 8'h02, 8'h34};
        run_load(8'd0, -1);
        stim = '{8'hED, 8'h08, 8'h55, 8'h99, 8'h12};
        run_load(8'd1, 3);

        for (int l = 0; l < 20; l++) begin
            logic [7:0] b;
            stim.delete();
            repeat ($urandom_range(1, 8)) begin
                case ($urandom_range(0, 4))
                    0, 1: begin
                        b = 8'($urandom_range(0, 255));
                        if (b == 8'hED) b = 8'hEC;
                        stim.push_back(b);
                    end
                    2, 3: begin
                        stim.push_back(8'hED);
                        stim.push_back(($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(1, 12)));
                        stim.push_back(8'($urandom_range(0, 255)));
                    end
                    default: begin
                        stim.push_back(8'hED);
                        stim.push_back(8'h00);
                        stim.push_back(8'($urandom_range(0, 255)));
                    end
                endcase
            end
            run_load(($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255)), -1);
        end

        // Abort after the second fill write.
        act_a.delete();
        @(negedge clk_sys);
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        mon_en         = 1'b1;
        @(negedge clk_sys);
        send_byte(8'hED, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h77, 1'b0);
        seen = 0;
        guard = 0;
        while (seen < 2 && guard < 100) begin
            @(negedge clk_sys);
            guard++;
            if (wr_a) seen++;
        end
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("abort_mem_wr", wr_a, 0);
        check("abort_mem_sel", sel_a, 0);
        check("abort_core_reset", crst_a, 0);
        check("abort_wait", wait_a, 0);
        repeat (3) @(negedge clk_sys);
        mon_en = 1'b0;
        check("abort_write_count", act_a.size(), 2);
`ifdef LOADER_CHECKSUM_EN
        check("abort_checksum", csum_a, 8'h00);
`endif

        // Reset pulse mid-run.
        @(negedge clk_sys);
        ioctl_index    = 8'd2;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        send_byte(8'hED, 1'b0);
        send_byte(8'h0A, 1'b0);
        send_byte(8'h3C, 1'b0);
        seen = 0;
        guard = 0;
        while (seen < 3 && guard < 100) begin
            @(negedge clk_sys);
            guard++;
            if (wr_a) seen++;
        end
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        check_reset_values();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_sys);
            check("post_reset_no_write", wr_a, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
